// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - run-mode sequencer, fetch PC and per-stage update control for the multi-cycle core
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   boot_rcvd              host boot byte received (pulse), IDLE -> LOAD
//   load_done, boot_sent   load handshakes, latched while in LOAD
//   ex_pc                  PC of the instruction in register EX_IDX
//   ex_wait, ex_busy       execute-stage extra latency / execute unit not ready
//   stop_req               execute-stage instruction is a stop
//   dec_jump, dec_target   decode-stage direct jump and its target
//   redirect, redirect_pc  mispredict from the last stage and the correct PC
//   resume                 leave HALT (pulse)
//   pc                     fetch address
//   mode                   IDLE=0, LOAD=1, EXEC=2, HALT=3
//   stage_update           per-stage code at [2i+1:2i]: 00 hold, 01 advance, 10 flush
//   stage_valid            register i holds a live instruction
//   ex_start               pulse: a new instruction entered execute
//   lat_cnt                cycles spent on the current execute instruction
//   retired                retired-instruction count
module pipeline_ctrl #(
  parameter int              NSTAGE   = 3,
  parameter int              EX_IDX   = 1,
  parameter int              XLEN     = 32,
  parameter int              LAT_W    = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                boot_rcvd,
  input  logic                load_done,
  input  logic                boot_sent,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic [LAT_W-1:0]    ex_wait,
  input  logic                ex_busy,
  input  logic                stop_req,
  input  logic                dec_jump,
  input  logic [XLEN-1:0]     dec_target,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                resume,
  output logic [XLEN-1:0]     pc,
  output logic [1:0]          mode,
  output logic [2*NSTAGE-1:0] stage_update,
  output logic [NSTAGE-1:0]   stage_valid,
  output logic                ex_start,
  output logic [LAT_W-1:0]    lat_cnt,
  output logic [31:0]         retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } mode_t;

  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;

  mode_t             mode_q, mode_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [NSTAGE-1:0] valid_q, valid_d;
  logic              ex_start_q, ex_start_d;
  logic [31:0]       retired_q, retired_d;
  logic              jdone_q, jdone_d;
  logic              load_seen_q, load_seen_d;
  logic              sent_seen_q, sent_seen_d;
  logic [1:0]        upd_code;

  logic in_exec;
  logic red, stp, jhold, adv;
  logic load_ok, sent_ok;

  assign in_exec = (mode_q == EXEC);

  // Qualified events; only meaningful while executing.
  assign red   = in_exec & redirect & valid_q[NSTAGE-1];
  assign stp   = in_exec & stop_req & valid_q[EX_IDX];
  // A jump in decode costs one hold cycle; jdone stops it from re-holding forever.
  assign jhold = in_exec & dec_jump & valid_q[0] & ~jdone_q;
  assign adv   = in_exec & (lat_q >= ex_wait) & ~ex_busy & ~jhold;

  // Handshakes may arrive before or in the same cycle as each other.
  assign load_ok = load_done | load_seen_q;
  assign sent_ok = boot_sent | sent_seen_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q      <= IDLE;
      pc_q        <= RESET_PC;
      halt_pc_q   <= RESET_PC;
      lat_q       <= '0;
      valid_q     <= '0;
      ex_start_q  <= 1'b0;
      retired_q   <= '0;
      jdone_q     <= 1'b0;
      load_seen_q <= 1'b0;
      sent_seen_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pc_q        <= pc_d;
      halt_pc_q   <= halt_pc_d;
      lat_q       <= lat_d;
      valid_q     <= valid_d;
      ex_start_q  <= ex_start_d;
      retired_q   <= retired_d;
      jdone_q     <= jdone_d;
      load_seen_q <= load_seen_d;
      sent_seen_q <= sent_seen_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    pc_d        = pc_q;
    halt_pc_d   = halt_pc_q;
    lat_d       = lat_q;
    valid_d     = valid_q;
    ex_start_d  = 1'b0;
    retired_d   = retired_q;
    jdone_d     = jdone_q;
    load_seen_d = load_seen_q;
    sent_seen_d = sent_seen_q;
    upd_code    = UPD_FLUSH;

    unique case (mode_q)
      IDLE: begin
        if (boot_rcvd) begin
          mode_d = LOAD;
          pc_d   = RESET_PC;
        end
      end
      LOAD: begin
        if (load_ok && sent_ok) begin
          mode_d      = EXEC;
          load_seen_d = 1'b0;
          sent_seen_d = 1'b0;
        end else begin
          load_seen_d = load_ok;
          sent_seen_d = sent_ok;
        end
      end
      EXEC: begin
        if (red) begin
          upd_code = UPD_FLUSH;
          valid_d  = '0;
          pc_d     = redirect_pc;
          lat_d    = '0;
          jdone_d  = 1'b0;
        end else if (stp) begin
          // The stop itself is discarded, so it never reaches retirement.
          upd_code  = UPD_FLUSH;
          valid_d   = '0;
          halt_pc_d = ex_pc + XLEN'(4);
          mode_d    = HALT;
        end else if (adv) begin
          upd_code   = UPD_ADV;
          valid_d    = {valid_q[NSTAGE-2:0], 1'b1};
          pc_d       = pc_q + XLEN'(4);
          lat_d      = '0;
          jdone_d    = 1'b0;
          ex_start_d = 1'b1;
          if (valid_q[NSTAGE-1]) begin
            retired_d = retired_q + 32'd1;
          end
        end else begin
          upd_code = UPD_HOLD;
          if (jhold) begin
            pc_d    = dec_target;
            jdone_d = 1'b1;
          end
          if ((lat_q < ex_wait) && (lat_q != {LAT_W{1'b1}})) begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
      end
      HALT: begin
        if (resume) begin
          mode_d = EXEC;
          pc_d   = halt_pc_q;
          lat_d  = '0;
        end
      end
      default: begin
        mode_d = IDLE;
      end
    endcase
  end

  assign pc           = pc_q;
  assign mode         = mode_q;
  assign stage_update = {NSTAGE{upd_code}};
  assign stage_valid  = valid_q;
  assign ex_start     = ex_start_q;
  assign lat_cnt      = lat_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with a behavioural reference model
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        boot_rcvd, load_done, boot_sent;
  logic [31:0] ex_pc;
  logic [4:0]  ex_wait;
  logic        ex_busy, stop_req, dec_jump;
  logic [31:0] dec_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        resume;
  logic [31:0] pc;
  logic [1:0]  mode;
  logic [5:0]  stage_update;
  logic [2:0]  stage_valid;
  logic        ex_start;
  logic [4:0]  lat_cnt;
  logic [31:0] retired;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .NSTAGE(3), .EX_IDX(1), .XLEN(32), .LAT_W(5), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .boot_rcvd(boot_rcvd), .load_done(load_done), .boot_sent(boot_sent),
    .ex_pc(ex_pc), .ex_wait(ex_wait), .ex_busy(ex_busy), .stop_req(stop_req),
    .dec_jump(dec_jump), .dec_target(dec_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .pc(pc), .mode(mode), .stage_update(stage_update), .stage_valid(stage_valid),
    .ex_start(ex_start), .lat_cnt(lat_cnt), .retired(retired)
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mode;
    logic [5:0]  upd;
    logic [2:0]  valid;
    logic        exs;
    logic [4:0]  lat;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, expv);
    end
  endtask

  // Reference model: run mode as an int (0 idle, 1 load, 2 exec, 3 halt), plain counters.
  int          m_mode;
  logic [31:0] m_pc, m_hpc, m_ret;
  int          m_lat;
  logic [2:0]  m_v;
  bit          m_exs, m_jd, m_ls, m_ss;

  task automatic m_reset();
    m_mode = 0; m_pc = 0; m_hpc = 0; m_ret = 0; m_lat = 0;
    m_v = 0; m_exs = 0; m_jd = 0; m_ls = 0; m_ss = 0;
  endtask

  // Push the outputs expected during this cycle, then advance the model to the next edge.
  task automatic model_step();
    exp_t e;
    int   code;
    bit   red, stp, jh, adv, ld, sn;
    if (!rstn) m_reset();
    code = 2;
    red = 0; stp = 0; jh = 0; adv = 0;
    if (rstn && m_mode == 2) begin
      red = redirect && m_v[2];
      stp = stop_req && m_v[1];
      jh  = dec_jump && m_v[0] && !m_jd;
      adv = (m_lat >= int'(ex_wait)) && !ex_busy && !jh;
      if (red || stp) code = 2;
      else if (adv)   code = 1;
      else            code = 0;
    end
    e.pc = m_pc; e.mode = 2'(m_mode); e.upd = {3{code[1:0]}};
    e.valid = m_v; e.exs = m_exs; e.lat = 5'(m_lat); e.ret = m_ret;
    exp_q.push_back(e);
    if (!rstn) return;
    m_exs = 0;
    case (m_mode)
      0: if (boot_rcvd) begin m_mode = 1; m_pc = 0; end
      1: begin
        ld = load_done || m_ls;
        sn = boot_sent || m_ss;
        if (ld && sn) begin m_mode = 2; m_ls = 0; m_ss = 0; end
        else begin m_ls = ld; m_ss = sn; end
      end
      2: begin
        if (red) begin
          m_v = 0; m_pc = redirect_pc; m_lat = 0; m_jd = 0;
        end else if (stp) begin
          m_v = 0; m_hpc = ex_pc + 32'd4; m_mode = 3;
        end else if (adv) begin
          if (m_v[2]) m_ret = m_ret + 32'd1;
          m_v = {m_v[1], m_v[0], 1'b1};
          m_pc = m_pc + 32'd4; m_lat = 0; m_jd = 0; m_exs = 1;
        end else begin
          if (jh) begin m_pc = dec_target; m_jd = 1; end
          if (m_lat < int'(ex_wait) && m_lat < 31) m_lat = m_lat + 1;
        end
      end
      default: if (resume) begin m_mode = 2; m_pc = m_hpc; m_lat = 0; end
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pc",           64'(pc),           64'(e.pc));
      chk("mode",         64'(mode),         64'(e.mode));
      chk("stage_update", 64'(stage_update), 64'(e.upd));
      chk("stage_valid",  64'(stage_valid),  64'(e.valid));
      chk("ex_start",     64'(ex_start),     64'(e.exs));
      chk("lat_cnt",      64'(lat_cnt),      64'(e.lat));
      chk("retired",      64'(retired),      64'(e.ret));
    end
  end

  task automatic clr_in();
    boot_rcvd = 0; load_done = 0; boot_sent = 0; ex_pc = 0; ex_wait = 0;
    ex_busy = 0; stop_req = 0; dec_jump = 0; dec_target = 0;
    redirect = 0; redirect_pc = 0; resume = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    64'(pc),           64'h0);
    chk({tag, "_mode"},  64'(mode),         64'h0);
    chk({tag, "_upd"},   64'(stage_update), 64'h2a);
    chk({tag, "_valid"}, 64'(stage_valid),  64'h0);
    chk({tag, "_exs"},   64'(ex_start),     64'h0);
    chk({tag, "_lat"},   64'(lat_cnt),      64'h0);
    chk({tag, "_ret"},   64'(retired),      64'h0);
  endtask

  initial begin
    logic [31:0] ret_frozen;
    rstn = 0;
    clr_in();
    #1;
    chk_reset_vals("reset0");
    @(posedge clk);
    #1;
    repeat (3) tick();

    // Boot: load_done three cycles ahead of boot_sent.
    rstn = 1;
    boot_rcvd = 1; tick();
    clr_in(); tick();
    load_done = 1; tick();
    clr_in(); tick(); tick();
    boot_sent = 1; tick();
    clr_in();
    chk("boot_mode", 64'(mode), 64'd2);
    chk("boot_pc",   64'(pc),   64'd0);

    // Straight-line code, back-to-back advances.
    repeat (4) tick();
    chk("straight_retired", 64'(retired), 64'd1);
    chk("straight_pc",      64'(pc),      64'd16);

    // ex_wait=3 plus two busy cycles: five holds then one advance.
    for (int i = 0; i < 6; i++) begin
      clr_in(); ex_wait = 3; ex_busy = (i == 3 || i == 4); tick();
    end
    clr_in();
    chk("wait_ex_start", 64'(ex_start), 64'd1);
    chk("wait_lat",      64'(lat_cnt),  64'd0);

    // Direct jump to 0x100.
    dec_jump = 1; dec_target = 32'h100; tick();
    chk("jump_hold_pc", 64'(pc), 64'h100);
    tick();
    clr_in();
    chk("jump_adv_pc", 64'(pc), 64'h104);

    // Redirect beats a simultaneous stop.
    redirect = 1; redirect_pc = 32'h40; stop_req = 1; tick();
    clr_in();
    chk("redir_pc",   64'(pc),   64'h40);
    chk("redir_mode", 64'(mode), 64'd2);

    // Stop, freeze, resume.
    tick(); tick();
    stop_req = 1; ex_pc = 32'h20; tick();
    clr_in();
    chk("stop_mode", 64'(mode), 64'd3);
    ret_frozen = m_ret;
    tick(); tick();
    chk("halt_retired_frozen", 64'(retired), 64'(ret_frozen));
    resume = 1; tick();
    clr_in();
    chk("resume_pc",   64'(pc),   64'h24);
    chk("resume_mode", 64'(mode), 64'd2);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      boot_rcvd   = ($urandom_range(0, 7) == 0);
      load_done   = ($urandom_range(0, 3) == 0);
      boot_sent   = ($urandom_range(0, 3) == 0);
      ex_pc       = $urandom & 32'hffff_fffc;
      ex_wait     = ($urandom_range(0, 31) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      ex_busy     = ($urandom_range(0, 3) == 0);
      stop_req    = ($urandom_range(0, 23) == 0);
      dec_jump    = ($urandom_range(0, 5) == 0);
      dec_target  = $urandom & 32'hffff_fffc;
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom & 32'hffff_fffc;
      resume      = ($urandom_range(0, 7) == 0);
      tick();
    end

    // Asynchronous reset mid-run, away from any clock edge.
    clr_in();
    rstn = 0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rstn = 1;
    repeat (5) tick();

    #10;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
